// File: rtl/mem_1r1w_rmw_ctrl_32x64.sv
// Request-side controller in front of an unmasked 1R1W SRAM (32x64).
// Zero-fills the array after reset, then serves reads and byte-masked writes (partial masks via RMW).
module mem_1r1w_rmw_ctrl_32x64 #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MASK_GRAN = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [WIDTH-1:0]              req_data,
  input  logic [WIDTH/MASK_GRAN-1:0]    req_mask,
  output logic                          resp_valid,
  output logic [WIDTH-1:0]              resp_data,
  output logic                          init_done,
  output logic [ADDR_W-1:0]             R0_addr,
  output logic                          R0_en,
  input  logic [WIDTH-1:0]              R0_data,
  output logic [ADDR_W-1:0]             W0_addr,
  output logic                          W0_en,
  output logic [WIDTH-1:0]              W0_data
);

  localparam int unsigned MASK_W = WIDTH / MASK_GRAN;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MERGE = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   saved_addr;
  logic [WIDTH-1:0]    saved_data;
  logic [MASK_W-1:0]   saved_mask;
  logic [WIDTH-1:0]    merged;
  logic                mask_full;
  logic                mask_none;
  logic                partial;

  assign mask_full = &req_mask;
  assign mask_none = ~|req_mask;
  assign partial   = req_write && !mask_full && !mask_none;

  // Read data is only presented while a response is pending; otherwise held at zero.
  assign resp_data = resp_valid ? R0_data : '0;

  // State, fill counter, response flag and saved RMW operands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      cnt        <= '0;
      init_done  <= 1'b0;
      resp_valid <= 1'b0;
      saved_addr <= '0;
      saved_data <= '0;
      saved_mask <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            if (!req_write) begin
              resp_valid <= 1'b1;
            end else if (partial) begin
              saved_addr <= req_addr;
              saved_data <= req_data;
              saved_mask <= req_mask;
              state      <= ST_MERGE;
            end
          end
        end
        ST_MERGE: state <= ST_IDLE;
        default:  state <= ST_INIT;
      endcase
    end
  end

  // Lane merge: new bytes where the saved mask is set, old SRAM bytes elsewhere.
  always_comb begin
    merged = R0_data;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (saved_mask[i]) begin
        merged[i*MASK_GRAN +: MASK_GRAN] = saved_data[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  // SRAM port drive and handshake, decoded in the accept cycle.
  always_comb begin
    req_ready = 1'b0;
    R0_en     = 1'b0;
    R0_addr   = req_addr;
    W0_en     = 1'b0;
    W0_addr   = req_addr;
    W0_data   = req_data;
    case (state)
      ST_INIT: begin
        W0_en   = 1'b1;
        W0_addr = cnt;
        W0_data = '0;
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!req_write || partial) begin
            R0_en = 1'b1;
          end else if (mask_full) begin
            W0_en = 1'b1;
          end
        end
      end
      ST_MERGE: begin
        W0_en   = 1'b1;
        W0_addr = saved_addr;
        W0_data = merged;
      end
      default: ;
    endcase
    // No SRAM activity while reset is held, even though the state already reads INIT.
    if (reset) begin
      W0_en     = 1'b0;
      R0_en     = 1'b0;
      req_ready = 1'b0;
    end
  end

endmodule
